// File: rtl/uart_baud_gen_frac.sv
// uart_baud_gen_frac
//
// Fractional-divider oversampling baud generator shared by the UART TX and RX.
// One prescaler produces an oversample tick whose period alternates between
// div and div+1 clk cycles. A FRAC_W-bit phase accumulator decides which
// periods get the extra cycle, so the long-run average is div + frac/2^FRAC_W.
// Two phase counters derive the TX bit-boundary strobe and the RX mid-bit
// strobe from the oversample tick. The RX phase can be re-aligned by the
// receiver's start-bit detector.
//
// Ports:
//   clk          system clock
//   rst_n        asynchronous, active-low reset
//   div_int      integer part of the oversample period (clk cycles)
//   div_frac     fractional part of the oversample period (1/2^FRAC_W cycle)
//   cfg_load     pulse: copy div_int/div_frac into the active divisor, restart
//   tx_en        level: enable TX timing
//   rx_en        level: enable RX timing
//   rx_sync      pulse: start-bit detected, restart RX phase
//   ovs_tick     oversample strobe (1 cycle)
//   tx_bit_tick  TX bit-boundary strobe (1 cycle)
//   rx_mid_tick  RX mid-bit sample strobe (1 cycle)
//   cfg_err      level: active integer divisor is below 2, generator halted

module uart_baud_gen_frac #(
  parameter int unsigned DIV_W    = 16,
  parameter int unsigned FRAC_W   = 4,
  parameter int unsigned OVS      = 16,
  parameter int unsigned DEF_DIV  = 78,
  parameter int unsigned DEF_FRAC = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DIV_W-1:0]  div_int,
  input  logic [FRAC_W-1:0] div_frac,
  input  logic              cfg_load,
  input  logic              tx_en,
  input  logic              rx_en,
  input  logic              rx_sync,
  output logic              ovs_tick,
  output logic              tx_bit_tick,
  output logic              rx_mid_tick,
  output logic              cfg_err
);

  localparam int unsigned PH_W = $clog2(OVS);
  localparam logic [PH_W-1:0]   PH_LAST   = PH_W'(OVS - 1);
  localparam logic [PH_W-1:0]   PH_MID_M1 = PH_W'(OVS / 2 - 1);
  localparam logic [DIV_W-1:0]  DEF_DIV_V  = DIV_W'(DEF_DIV);
  localparam logic [FRAC_W-1:0] DEF_FRAC_V = FRAC_W'(DEF_FRAC);
  localparam logic              DEF_ERR    = (DEF_DIV < 2);

  logic [DIV_W-1:0]  div_q,   div_d;
  logic [FRAC_W-1:0] frac_q,  frac_d;
  logic              err_q,   err_d;
  logic [DIV_W-1:0]  pcnt_q,  pcnt_d;
  logic [FRAC_W-1:0] acc_q,   acc_d;
  logic              carry_q, carry_d;
  logic [PH_W-1:0]   tx_ph_q, tx_ph_d;
  logic [PH_W-1:0]   rx_ph_q, rx_ph_d;
  logic              ovs_tick_q, ovs_tick_d;
  logic              tx_tick_q,  tx_tick_d;
  logic              rx_tick_q,  rx_tick_d;

  logic              run;
  logic              wrap;
  logic [DIV_W:0]    limit;
  logic [DIV_W:0]    limit_m1;
  logic [FRAC_W:0]   acc_sum;

  // Period length is div + carry, which can reach 2^DIV_W, so the terminal
  // count is formed one bit wider than pcnt.
  always_comb begin
    run      = (tx_en | rx_en) & ~err_q;
    limit    = {1'b0, div_q} + (DIV_W + 1)'(carry_q);
    limit_m1 = limit - (DIV_W + 1)'(1);
    wrap     = run & ({1'b0, pcnt_q} == limit_m1);
    acc_sum  = {1'b0, acc_q} + {1'b0, frac_q};
  end

  // Next-state logic. cfg_load outranks everything: it restarts all counters
  // and swallows any wrap on the same edge. rx_sync outranks a coincident
  // wrap for the RX phase only; the oversample tick still fires.
  always_comb begin
    div_d      = div_q;
    frac_d     = frac_q;
    err_d      = err_q;
    pcnt_d     = pcnt_q;
    acc_d      = acc_q;
    carry_d    = carry_q;
    tx_ph_d    = tx_ph_q;
    rx_ph_d    = rx_ph_q;
    ovs_tick_d = 1'b0;
    tx_tick_d  = 1'b0;
    rx_tick_d  = 1'b0;

    if (cfg_load) begin
      div_d   = div_int;
      frac_d  = div_frac;
      err_d   = (div_int < DIV_W'(2));
      pcnt_d  = '0;
      acc_d   = '0;
      carry_d = 1'b0;
      tx_ph_d = '0;
      rx_ph_d = '0;
    end else begin
      // Carry is dropped while idle so the first period after enable is div.
      if (!run) begin
        pcnt_d  = '0;
        acc_d   = '0;
        carry_d = 1'b0;
      end else if (wrap) begin
        pcnt_d     = '0;
        acc_d      = acc_sum[FRAC_W-1:0];
        carry_d    = acc_sum[FRAC_W];
        ovs_tick_d = 1'b1;
      end else begin
        pcnt_d = pcnt_q + DIV_W'(1);
      end

      if (!tx_en) begin
        tx_ph_d = '0;
      end else if (wrap) begin
        tx_ph_d   = tx_ph_q + PH_W'(1);
        tx_tick_d = (tx_ph_q == PH_LAST);
      end

      if (!rx_en || rx_sync) begin
        rx_ph_d = '0;
      end else if (wrap) begin
        rx_ph_d   = rx_ph_q + PH_W'(1);
        rx_tick_d = (rx_ph_q == PH_MID_M1);
      end
    end
  end

  // State register; reset restores the default divisor and clears the rest.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q      <= DEF_DIV_V;
      frac_q     <= DEF_FRAC_V;
      err_q      <= DEF_ERR;
      pcnt_q     <= '0;
      acc_q      <= '0;
      carry_q    <= 1'b0;
      tx_ph_q    <= '0;
      rx_ph_q    <= '0;
      ovs_tick_q <= 1'b0;
      tx_tick_q  <= 1'b0;
      rx_tick_q  <= 1'b0;
    end else begin
      div_q      <= div_d;
      frac_q     <= frac_d;
      err_q      <= err_d;
      pcnt_q     <= pcnt_d;
      acc_q      <= acc_d;
      carry_q    <= carry_d;
      tx_ph_q    <= tx_ph_d;
      rx_ph_q    <= rx_ph_d;
      ovs_tick_q <= ovs_tick_d;
      tx_tick_q  <= tx_tick_d;
      rx_tick_q  <= rx_tick_d;
    end
  end

  assign ovs_tick    = ovs_tick_q;
  assign tx_bit_tick = tx_tick_q;
  assign rx_mid_tick = rx_tick_q;
  assign cfg_err     = err_q;

endmodule

// File: tb/tb_uart_baud_gen_frac.sv
// Testbench for uart_baud_gen_frac: directed stimulus, a cycle-level reference
// model built from period arithmetic, and hand-computed timing expectations.

module tb_uart_baud_gen_frac;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] div_int;
   logic [3:0]  div_frac;
   logic        cfg_load;
   logic        tx_en;
   logic        rx_en;
   logic        rx_sync;
   logic        ovs_tick;
   logic        tx_bit_tick;
   logic        rx_mid_tick;
   logic        cfg_err;

   int compared   = 0;
   int mismatched = 0;

   // Reference model state: elapsed cycles in the current oversample period,
   // wraps since restart, and the two phase positions.
   int mDiv     = 78;
   int mFrac    = 2;
   bit mErr     = 1'b0;
   int mElapsed = 0;
   int mWraps   = 0;
   int mTxPh    = 0;
   int mRxPh    = 0;
   bit eOvs     = 1'b0;
   bit eTx      = 1'b0;
   bit eRx      = 1'b0;

   uart_baud_gen_frac dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .div_int     (div_int),
      .div_frac    (div_frac),
      .cfg_load    (cfg_load),
      .tx_en       (tx_en),
      .rx_en       (rx_en),
      .rx_sync     (rx_sync),
      .ovs_tick    (ovs_tick),
      .tx_bit_tick (tx_bit_tick),
      .rx_mid_tick (rx_mid_tick),
      .cfg_err     (cfg_err)
   );

   always #5 clk = ~clk;

   // Extra cycle owed to period k: how many times k*frac/16 crossed an
   // integer since period k-1. The first period after a restart never has one.
   function automatic int carryOf(input int k, input int frac);
      if (k == 0) return 0;
      return (k * frac) / 16 - ((k - 1) * frac) / 16;
   endfunction

   task automatic checkOutput(input string name, input int actual, input int expected);
      compared++;
      if (actual != expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
      end
   endtask

   // Drive all inputs for one cycle, then drop the pulse inputs.
   task automatic applyStimulus(input bit load, input int dInt, input int dFrac,
                                input bit txEn, input bit rxEn, input bit sync);
      cfg_load = load;
      div_int  = 16'(dInt);
      div_frac = 4'(dFrac);
      tx_en    = txEn;
      rx_en    = rxEn;
      rx_sync  = sync;
      @(negedge clk);
      cfg_load = 1'b0;
      rx_sync  = 1'b0;
   endtask

   // Advance negedge by negedge until the selected strobe is seen; n is the
   // number of clock edges consumed, or -1 if the bound expired.
   task automatic waitTick(input int which, input int maxCycles, output int n);
      bit hit;
      n = 0;
      do begin
         @(negedge clk);
         n++;
         hit = (which == 0) ? ovs_tick : (which == 1) ? tx_bit_tick : rx_mid_tick;
      end while (!hit && n < maxCycles);
      if (!hit) begin
         checkOutput("tickTimeout", n, -1);
         n = -1;
      end
   endtask

   // Reference model, advanced on the same edge as the DUT.
   always @(posedge clk or negedge rst_n) begin
      int nElapsed;
      int nWraps;
      int nTx;
      int nRx;
      bit wrapNow;
      bit running;
      bit tTx;
      bit tRx;
      if (!rst_n) begin
         mDiv     <= 78;
         mFrac    <= 2;
         mErr     <= 1'b0;
         mElapsed <= 0;
         mWraps   <= 0;
         mTxPh    <= 0;
         mRxPh    <= 0;
         eOvs     <= 1'b0;
         eTx      <= 1'b0;
         eRx      <= 1'b0;
      end else if (cfg_load) begin
         mDiv     <= int'(div_int);
         mFrac    <= int'(div_frac);
         mErr     <= (div_int < 16'd2);
         mElapsed <= 0;
         mWraps   <= 0;
         mTxPh    <= 0;
         mRxPh    <= 0;
         eOvs     <= 1'b0;
         eTx      <= 1'b0;
         eRx      <= 1'b0;
      end else begin
         running  = (tx_en || rx_en) && !mErr;
         wrapNow  = 1'b0;
         nElapsed = 0;
         nWraps   = 0;
         if (running) begin
            nElapsed = mElapsed + 1;
            nWraps   = mWraps;
            if (nElapsed == mDiv + carryOf(mWraps, mFrac)) begin
               wrapNow  = 1'b1;
               nElapsed = 0;
               nWraps   = mWraps + 1;
            end
         end
         nTx = mTxPh;
         tTx = 1'b0;
         if (!tx_en) nTx = 0;
         else if (wrapNow) begin
            tTx = (mTxPh == 15);
            nTx = (mTxPh + 1) % 16;
         end
         nRx = mRxPh;
         tRx = 1'b0;
         if (!rx_en || rx_sync) nRx = 0;
         else if (wrapNow) begin
            tRx = (mRxPh == 7);
            nRx = (mRxPh + 1) % 16;
         end
         mElapsed <= nElapsed;
         mWraps   <= nWraps;
         mTxPh    <= nTx;
         mRxPh    <= nRx;
         eOvs     <= wrapNow;
         eTx      <= tTx;
         eRx      <= tRx;
      end
   end

   // Cycle-by-cycle comparison of every output against the model.
   always @(negedge clk) begin
      checkOutput("ovs_tick",    int'(ovs_tick),    int'(eOvs));
      checkOutput("tx_bit_tick", int'(tx_bit_tick), int'(eTx));
      checkOutput("rx_mid_tick", int'(rx_mid_tick), int'(eRx));
      checkOutput("cfg_err",     int'(cfg_err),     int'(mErr));
   end

   initial begin
      #5_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int n;
      int c78;
      int c79;
      int ticks;
      int stray;

      rst_n    = 1'b0;
      div_int  = '0;
      div_frac = '0;
      cfg_load = 1'b0;
      tx_en    = 1'b0;
      rx_en    = 1'b0;
      rx_sync  = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("resetOvs", int'(ovs_tick), 0);
      checkOutput("resetTx",  int'(tx_bit_tick), 0);
      checkOutput("resetRx",  int'(rx_mid_tick), 0);
      checkOutput("resetErr", int'(cfg_err), 0);

      // Default 78 + 2/16 divisor: first bit boundary after 16*78 + 1 edges.
      rst_n = 1'b1;
      tx_en = 1'b1;
      waitTick(1, 3000, n);
      checkOutput("defFirstBit", n, 1249);
      c78 = 0;
      c79 = 0;
      for (int i = 0; i < 16; i++) begin
         waitTick(0, 200, n);
         if (n == 78) c78++;
         else if (n == 79) c79++;
      end
      checkOutput("defCount78", c78, 14);
      checkOutput("defCount79", c79, 2);
      checkOutput("defBitAfter16", int'(tx_bit_tick), 1);

      // Asynchronous reset while a strobe is showing.
      waitTick(0, 200, n);
      #1 rst_n = 1'b0;
      #1;
      checkOutput("asyncRstOvs", int'(ovs_tick), 0);
      checkOutput("asyncRstErr", int'(cfg_err), 0);
      @(negedge clk);
      rst_n = 1'b1;
      waitTick(1, 3000, n);
      checkOutput("rstRestartBit", n, 1249);

      // Integer divisor 4: ovs every 4, bit every 64 from enable.
      applyStimulus(1'b1, 4, 0, 1'b0, 1'b0, 1'b0);
      tx_en = 1'b1;
      waitTick(0, 20, n);
      checkOutput("div4FirstOvs", n, 4);
      waitTick(0, 20, n);
      checkOutput("div4OvsSpacing", n, 4);
      waitTick(1, 200, n);
      checkOutput("div4FirstBit", n, 56);
      waitTick(1, 200, n);
      checkOutput("div4BitSpacing", n, 64);

      // Reload mid-bit (tx phase 7): next bit is a full 16 x 5 cycles later.
      repeat (7) waitTick(0, 20, n);
      applyStimulus(1'b1, 5, 0, 1'b1, 1'b0, 1'b0);
      waitTick(1, 200, n);
      checkOutput("midBitReload", n, 80);

      // RX: sync coincident with a wrap keeps the phase at 0.
      applyStimulus(1'b1, 4, 0, 1'b0, 1'b1, 1'b0);
      waitTick(0, 20, n);
      checkOutput("rxFirstOvs", n, 4);
      repeat (3) @(negedge clk);
      applyStimulus(1'b0, 4, 0, 1'b0, 1'b1, 1'b1);
      checkOutput("syncWrapOvs", int'(ovs_tick), 1);
      checkOutput("syncWrapMid", int'(rx_mid_tick), 0);
      ticks = 0;
      do begin
         waitTick(0, 20, n);
         ticks++;
      end while (!rx_mid_tick && ticks < 40);
      checkOutput("rxMidAfterSync", ticks, 8);
      ticks = 0;
      do begin
         waitTick(0, 20, n);
         ticks++;
      end while (!rx_mid_tick && ticks < 40);
      checkOutput("rxMidSpacing", ticks, 16);

      // Illegal divisor halts everything until a legal reload.
      applyStimulus(1'b1, 1, 0, 1'b1, 1'b1, 1'b0);
      checkOutput("errSet", int'(cfg_err), 1);
      stray = 0;
      repeat (1000) begin
         @(negedge clk);
         stray += int'(ovs_tick) + int'(tx_bit_tick) + int'(rx_mid_tick);
      end
      checkOutput("errNoTicks", stray, 0);
      applyStimulus(1'b1, 10, 0, 1'b1, 1'b1, 1'b0);
      checkOutput("errClear", int'(cfg_err), 0);
      waitTick(0, 50, n);
      checkOutput("div10FirstOvs", n, 10);
      waitTick(0, 50, n);
      checkOutput("div10OvsSpacing", n, 10);

      // Fractional divisor 3 + 5/16 with enables toggling and sync pulses,
      // including one sync while RX is disabled; checked by the model only.
      applyStimulus(1'b1, 3, 5, 1'b1, 1'b1, 1'b0);
      for (int i = 0; i < 400; i++) begin
         applyStimulus(1'b0, 3, 5, (i < 200) || (i >= 260), i < 300,
                       (i == 97) || (i == 150) || (i == 320));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/uart_baud_gen_frac.md
# uart_baud_gen_frac

Fractional-divider, oversampling baud generator for the UART transmitter and receiver. It produces three strobes from one shared prescaler: an oversample tick, a TX bit strobe and an RX mid-bit strobe. The divisor is programmable at runtime, and the RX phase re-aligns to the receiver's start-bit detection. Baud rates such as 9600 at 12 MHz therefore hit the target rate without integer-rounding error.

## Interface
- DIV_W, 16: width of the integer divisor.
- FRAC_W, 4: width of the fractional divisor. The fraction unit is 1/2^FRAC_W clk cycle.
- OVS, 16: oversample ticks per bit. Must be a power of two and at least 4.
- DEF_DIV, 78: reset value of the active integer divisor.
- DEF_FRAC, 2: reset value of the active fractional divisor. 12 MHz / (16 × 78.125) = 9600 baud.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- div_int  in  DIV_W  integer part of the oversample period, in clk cycles.
- div_frac  in  FRAC_W  fractional part of the oversample period.
- cfg_load  in  1  single-cycle pulse; copies div_int/div_frac into the active registers.
- tx_en  in  1  TX timing enable (level).
- rx_en  in  1  RX timing enable (level).
- rx_sync  in  1  single-cycle pulse from the receiver at start-bit falling edge detection; restarts RX phase.
- ovs_tick  out  1  oversample strobe, one cycle wide.
- tx_bit_tick  out  1  TX bit-boundary strobe, one cycle wide.
- rx_mid_tick  out  1  RX mid-bit sample strobe, one cycle wide.
- cfg_err  out  1  level; high while the active div_int is less than 2.

## Operation
- Reset: active divisor = DEF_DIV/DEF_FRAC. pcnt, acc, tx_ph and rx_ph are 0. All outputs are 0.
- run = (tx_en | rx_en) & !cfg_err.
  - When run is low: pcnt and acc are held at 0 and no ticks are produced.
- Prescaler pcnt:
  - Counts 0..limit-1, where limit = div_int + carry.
  - carry is the carry-out of the most recent acc update. It is 0 for the first period after enable or load.
  - At wrap: pcnt goes to 0, acc becomes (acc + div_frac) mod 2^FRAC_W, and the carry is latched for the next period.
  - Long-run average period is exactly div_int + div_frac/2^FRAC_W cycles.
- TX phase tx_ph (log2(OVS) bits):
  - Cleared while tx_en is low.
  - Increments mod OVS on each wrap while tx_en is high.
  - tx_bit_tick fires with the wrap that moves tx_ph from OVS-1 to 0.
- RX phase rx_ph:
  - Cleared while rx_en is low.
  - Increments mod OVS on each wrap.
  - rx_mid_tick fires with the wrap that moves rx_ph from OVS/2-1 to OVS/2.
  - rx_sync with rx_en high sets rx_ph to 0 and has priority over a coincident wrap (that wrap does not advance rx_ph).
  - rx_sync with rx_en low is ignored.
- cfg_load:
  - Updates the active divisor.
  - On the same edge it clears pcnt, acc, carry, tx_ph and rx_ph.
  - It has priority over a coincident wrap; no tick is emitted for that wrap.
  - cfg_err updates from the new div_int on that edge.
- cfg_err high: generator halted, no ticks. It recovers only via cfg_load with div_int ≥ 2.
- Width rule: pcnt is DIV_W bits. limit can reach 2^DIV_W, so the compare uses DIV_W+1 bits.

## Timing
- All outputs are registered. Each strobe is high for exactly one cycle.
- ovs_tick is high in the cycle after the edge where pcnt wraps.
- tx_bit_tick and rx_mid_tick are coincident with the ovs_tick of their wrap.
- Start-up: let E1 be the first edge at which run is sampled high. The first ovs_tick is visible after edge E(div_int). The first tx_bit_tick follows OVS × div_int cycles later when div_frac = 0.
- rx_sync at edge S (no cfg_load): first rx_mid_tick follows after (OVS/2) oversample periods, measured from the pcnt phase at S. Subsequent rx_mid_ticks are every OVS ovs_ticks.
- Dropping tx_en or rx_en takes effect on the next edge; a strobe already registered still completes.
- Async reset mid-operation: all state and outputs go to 0 immediately, and the active divisor returns to its defaults.

## Test plan
- Reset defaults, tx_en=1 for 1 s at 12 MHz:
  - ovs_tick period alternates 78/79 cycles in a 14:2 pattern per 16.
  - Exactly 9600 tx_bit_tick ±1.
- cfg_load with div_int=4, div_frac=0, tx_en=1:
  - First ovs_tick after the 4th enabled edge, then every 4 cycles.
  - tx_bit_tick every 64 cycles.
- rx_en=1 with div_int=4, div_frac=0:
  - Pulse rx_sync coincident with a wrap: rx_ph stays 0.
  - rx_mid_tick arrives 8 ovs_ticks later, then every 16.
- cfg_load with div_int=1: cfg_err=1 and no ticks for 1000 cycles. Then cfg_load with div_int=10: cfg_err=0 and ticks resume at 10-cycle spacing.
- cfg_load mid-bit (tx_ph=7): counters are cleared and the next tx_bit_tick is exactly 16 × new period later.
- Assert rst_n=0 mid-count: all outputs are 0 within the same cycle. On release, the 9600-baud default pattern restarts from phase 0.
